// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants and types for the writeback path.
//   REG_ADDR_W / NUM_REGS  : register-file geometry (32 x WORD_LENGTH_DEF)
//   wb_state_t             : writeback output-stage state (IDLE / PEND)
//   REQ_*                  : conventional requester slots on the writeback arbiter
package regfile_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int NUM_REGS        = 32;
    localparam int WORD_LENGTH_DEF = 32;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_PEND = 1'b1
    } wb_state_t;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
//   req     in  N         request vector
//   en      in  1         grant allowed this cycle
//   ptr     in  IDX_W     highest-priority index for this cycle
//   gnt     out N         one-hot grant (zero when en=0 or no request)
//   gnt_idx out IDX_W     index of the granted request (0 when none)
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    int   idx;
    logic found;

    // Walk N slots starting at ptr; the first requesting slot wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between NUM_REQ
// writeback sources with round-robin arbitration and a one-entry output stage.
//   clk, rst                 clock, async active-high reset
//   req_valid / req_ready    per-requester handshake (ready is one-hot or zero)
//   req_addr / req_data      packed per-requester address / data, slot i at [i*W +: W]
//   wb_stall                 holds the pending write and blocks new accepts
//   write_add/_data/_enable  straight to register_file write port
//   grant_id                 requester that owns the pending write
//   busy                     a write is pending
//   x0_drop_cnt              (only with WB_X0_DROP_CNT_EN) saturating count of
//                            accepted x0 writes
module regfile_wb_arbiter #(
    parameter int WORD_LENGTH = regfile_pkg::WORD_LENGTH_DEF,
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = regfile_pkg::REG_ADDR_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
    input  logic                           wb_stall,
    output logic [ADDR_W-1:0]              write_add,
    output logic [WORD_LENGTH-1:0]         write_data,
    output logic                           write_enable,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy
`ifdef WB_X0_DROP_CNT_EN
    ,
    output logic [15:0]                    x0_drop_cnt
`endif
);
    import regfile_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    wb_state_t             state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr;
    logic [NUM_REQ-1:0]    gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  can_accept;
    logic                  grant_any;
    logic [ADDR_W-1:0]     win_addr;
    logic [WORD_LENGTH-1:0] win_data;

    // A new write may enter when the stage is empty or is draining this cycle.
    // Holding off during rst keeps ready low while reset is asserted.
    assign can_accept = ((state_q == WB_IDLE) || !wb_stall) && !rst;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req     (req_valid),
        .en      (can_accept),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign grant_any = |gnt;
    assign win_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign win_data  = req_data[int'(gnt_idx)*WORD_LENGTH +: WORD_LENGTH];

    // x0 writes occupy the stage like any other but never reach the file.
    assign busy         = (state_q == WB_PEND);
    assign write_enable = busy && !wb_stall && (write_add != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: if (grant_any) state_d = WB_PEND;
            WB_PEND: if (!wb_stall) state_d = grant_any ? WB_PEND : WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WB_IDLE;
            write_add  <= '0;
            write_data <= '0;
            grant_id   <= '0;
            rr_ptr     <= '0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                write_add  <= win_addr;
                write_data <= win_data;
                grant_id   <= gnt_idx;
                rr_ptr     <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            end
        end
    end

`ifdef WB_X0_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            x0_drop_cnt <= '0;
        else if (grant_any && win_addr == '0 && x0_drop_cnt != 16'hFFFF)
            x0_drop_cnt <= x0_drop_cnt + 16'd1;
    end
`endif

endmodule
